trig_oneshot_bank: RTL and testbench
====================================

TRIG_ONESHOT_BANK -- requirements
Module: trig_oneshot_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent trigger/monitor channels (1..32).
REQ-002 Parameter LEN_W, default 5: width of the one-shot length field.
REQ-003 Parameter DEFAULT_LEN, default 16: one-shot length loaded at reset (1..2^LEN_W-1).
REQ-004 clk250_i  in  1  single 250 MHz clock; all logic is clocked on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 trig_i  in  NCH  per-channel trigger strobe, sampled every cycle.
REQ-007 pulse_i  in  NCH  per-channel reference pulse, qualified by that channel's scal_o.
REQ-008 mask_i  in  NCH  per-channel trigger mask; 1 = trig_i[k] ignored.
REQ-009 len_i  in  LEN_W  new one-shot length.
REQ-010 len_load_i  in  1  strobe; loads len_i into the length register.
REQ-011 retrig_i  in  1  mode: 1 = retriggerable, 0 = non-retriggerable.
REQ-012 scal_o  out  NCH  per-channel trigger one-shot.
REQ-013 mon_scal_o  out  NCH  per-channel monitor one-shot (reference pulse seen inside the trigger window).
REQ-014 busy_o  out  1  OR of all scal_o bits.

Function
REQ-015 The length register L updates on the edge after len_load_i=1; a loaded value of 0 is stored as 1.
REQ-016 Each one-shot latches L when it fires or reloads; a change to L never alters a pulse already in progress.
REQ-017 Each channel has one down-counter per one-shot of width LEN_W; a one-shot output is 1 exactly while its counter is non-zero.
REQ-018 Trigger fire: trig_i[k]=1 and mask_i[k]=0 sampled at edge n with scal_o[k]=0 sets scal_o[k]=1 from edge n+1 through the cycle ending at edge n+1+L (L cycles high).
REQ-019 Retriggerable mode: a qualified trigger sampled while scal_o[k]=1, including its last cycle, reloads the counter, so scal_o[k] stays high for L cycles after the latest trigger with no low gap.
REQ-020 Non-retriggerable mode: a qualified trigger sampled while scal_o[k]=1, including its last cycle, is ignored, so scal_o[k] is low for at least one cycle between pulses.
REQ-021 A trigger held high continuously: retriggerable mode keeps scal_o[k] high; non-retriggerable mode gives L cycles high, 1 cycle low, repeating.
REQ-022 Monitor qualify: g[k] = scal_o[k] AND pulse_i[k] passes through a two-stage register s0/s1; edge e[k] = s0 AND NOT s1.
REQ-023 A monitor pulse fires when e[k]=1. With pulse_i[k] rising at edge n while scal_o[k]=1, mon_scal_o[k] is high from edge n+2 for L cycles.
REQ-024 The monitor one-shot follows the same retrig_i rules as the trigger one-shot, with e[k] as its trigger; a held-high pulse_i gives exactly one edge.
REQ-025 mask_i gates only trig_i; the monitor of a masked channel still completes any pulse in progress.
REQ-026 Channels are fully independent; simultaneous triggers on any subset behave identically per channel.
REQ-027 A retrig_i change takes effect for triggers sampled on the same edge; running counters are not modified.
REQ-028 busy_o is combinational from the scal_o registers, with zero added latency.

Reset
REQ-029 With rst_i=1 at an edge, at that edge: all counters, s0/s1, scal_o, mon_scal_o and busy_o go to 0, and L goes to DEFAULT_LEN.
REQ-030 Reset has priority over trig_i, pulse_i and len_load_i on the same edge.
REQ-031 Reset during an active pulse forces the output low on that edge; nothing resumes after reset deasserts.
REQ-032 The first trigger sampled on the edge after rst_i deasserts is honoured.

Verification
REQ-033 Test 1, basic fire: L=16, retrig_i=0, trig_i[0] 1-cycle at edge 10 -> scal_o[0] high edges 11..26 (16 cycles); other channels stay 0.
REQ-034 Test 2, retrig and non-retrig: L=4, triggers at edges 0 and 3. With retrig_i=1 -> scal_o high from edge 1 through 7. With retrig_i=0 -> scal_o high from edge 1 through 4, and the trigger at edge 3 is ignored.
REQ-035 Test 3, monitor: L=8, trig at edge 0, pulse_i held high from edge 3 to 20 -> mon_scal_o high from edge 5 for 8 cycles, with exactly one firing.
REQ-036 Test 4, length load: len_i=0 with len_load_i -> L=1, trig gives a 1-cycle scal_o. Load len_i=10 mid-pulse -> the current pulse is unchanged and the next pulse is 10 cycles.
REQ-037 Test 5, mask and reset: mask_i[2]=1 with trig_i[2] -> no output. Reset asserted 3 cycles into an active pulse on all channels -> all outputs 0 on that edge and L=DEFAULT_LEN.

Source files
------------

// File: rtl/trig_oneshot_bank.sv
// Bank of NCH independent trigger one-shots, each paired with a monitor one-shot
// that fires on the first reference pulse seen inside that channel's trigger window.
module trig_oneshot_bank #(
  parameter int NCH         = 4,
  parameter int LEN_W       = 5,
  parameter int DEFAULT_LEN = 16
) (
  input  logic             clk250_i,
  input  logic             rst_i,
  input  logic [NCH-1:0]   trig_i,
  input  logic [NCH-1:0]   pulse_i,
  input  logic [NCH-1:0]   mask_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             len_load_i,
  input  logic             retrig_i,
  output logic [NCH-1:0]   scal_o,
  output logic [NCH-1:0]   mon_scal_o,
  output logic             busy_o
);

  localparam logic [LEN_W-1:0] ZERO    = LEN_W'(0);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] DEF_LEN = LEN_W'(DEFAULT_LEN);

  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] len_eff_s;

  logic [LEN_W-1:0] trig_cnt_r     [NCH];
  logic [LEN_W-1:0] trig_cnt_nxt_s [NCH];
  logic [LEN_W-1:0] mon_cnt_r      [NCH];
  logic [LEN_W-1:0] mon_cnt_nxt_s  [NCH];

  logic [NCH-1:0] scal_r;
  logic [NCH-1:0] mon_scal_r;
  logic [NCH-1:0] scal_nxt_s;
  logic [NCH-1:0] mon_scal_nxt_s;
  logic [NCH-1:0] s0_r;
  logic [NCH-1:0] s1_r;
  logic [NCH-1:0] edge_s;
  logic [NCH-1:0] trig_fire_s;
  logic [NCH-1:0] mon_fire_s;

  // A fire (or reload) latches the current length; otherwise count down to zero and hold.
  function automatic logic [LEN_W-1:0] next_count(
    input logic [LEN_W-1:0] cnt,
    input logic             fire,
    input logic [LEN_W-1:0] len
  );
    if (fire) begin
      return len;
    end else if (cnt != ZERO) begin
      return cnt - ONE;
    end else begin
      return cnt;
    end
  endfunction

  // Zero is not a usable length, so it is promoted to a single cycle.
  always_comb begin
    if (len_i == ZERO) begin
      len_eff_s = ONE;
    end else begin
      len_eff_s = len_i;
    end
  end

  // Length register.
  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      len_r <= DEF_LEN;
    end else if (len_load_i) begin
      len_r <= len_eff_s;
    end else begin
      len_r <= len_r;
    end
  end

  assign edge_s = s0_r & ~s1_r;

  // Fire qualification and next counter values for both one-shots of every channel.
  always_comb begin
    trig_fire_s    = {NCH{1'b0}};
    mon_fire_s     = {NCH{1'b0}};
    scal_nxt_s     = {NCH{1'b0}};
    mon_scal_nxt_s = {NCH{1'b0}};
    trig_cnt_nxt_s = trig_cnt_r;
    mon_cnt_nxt_s  = mon_cnt_r;
    for (int k = 0; k < NCH; k++) begin
      // Non-retriggerable mode refuses any trigger while the output is still high.
      trig_fire_s[k]    = trig_i[k] & ~mask_i[k] & (retrig_i | ~scal_r[k]);
      mon_fire_s[k]     = edge_s[k] & (retrig_i | ~mon_scal_r[k]);
      trig_cnt_nxt_s[k] = next_count(trig_cnt_r[k], trig_fire_s[k], len_r);
      mon_cnt_nxt_s[k]  = next_count(mon_cnt_r[k], mon_fire_s[k], len_r);
      scal_nxt_s[k]     = (trig_cnt_nxt_s[k] != ZERO);
      mon_scal_nxt_s[k] = (mon_cnt_nxt_s[k] != ZERO);
    end
  end

  // Counters, output flags and the monitor qualify pipeline.
  always_ff @(posedge clk250_i) begin
    if (rst_i) begin
      for (int k = 0; k < NCH; k++) begin
        trig_cnt_r[k] <= ZERO;
        mon_cnt_r[k]  <= ZERO;
      end
      scal_r     <= {NCH{1'b0}};
      mon_scal_r <= {NCH{1'b0}};
      s0_r       <= {NCH{1'b0}};
      s1_r       <= {NCH{1'b0}};
    end else begin
      for (int k = 0; k < NCH; k++) begin
        trig_cnt_r[k] <= trig_cnt_nxt_s[k];
        mon_cnt_r[k]  <= mon_cnt_nxt_s[k];
      end
      scal_r     <= scal_nxt_s;
      mon_scal_r <= mon_scal_nxt_s;
      s0_r       <= scal_r & pulse_i;
      s1_r       <= s0_r;
    end
  end

  assign scal_o     = scal_r;
  assign mon_scal_o = mon_scal_r;
  assign busy_o     = |scal_r;

endmodule

// File: tb/tb_trig_oneshot_bank.sv
// Table-driven bench for trig_oneshot_bank: each row is driven before an edge and the
// outputs after that edge are checked through a scoreboard queue.
module tb_trig_oneshot_bank;

  logic       clk250_s;
  logic       rst_s;
  logic [3:0] trig_s;
  logic [3:0] pulse_s;
  logic [3:0] mask_s;
  logic [4:0] len_s;
  logic       len_load_s;
  logic       retrig_s;
  logic [3:0] scal_s;
  logic [3:0] mon_scal_s;
  logic       busy_s;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       rst;
    logic [3:0] trig;
    logic [3:0] pulse;
    logic [3:0] mask;
    logic [4:0] len;
    logic       ld;
    logic       rt;
    logic [3:0] es;
    logic [3:0] em;
  } vec_t;

  typedef struct {
    int         row;
    logic [3:0] es;
    logic [3:0] em;
    logic       eb;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  trig_oneshot_bank #(.NCH(4), .LEN_W(5), .DEFAULT_LEN(16)) dut (
    .clk250_i   (clk250_s),
    .rst_i      (rst_s),
    .trig_i     (trig_s),
    .pulse_i    (pulse_s),
    .mask_i     (mask_s),
    .len_i      (len_s),
    .len_load_i (len_load_s),
    .retrig_i   (retrig_s),
    .scal_o     (scal_s),
    .mon_scal_o (mon_scal_s),
    .busy_o     (busy_s)
  );

  initial clk250_s = 1'b0;
  always #2 clk250_s = ~clk250_s;

  task automatic row(input logic r, input logic [3:0] trig, input logic [3:0] pulse,
                     input logic [3:0] mask, input logic [4:0] len, input logic ld,
                     input logic rt, input logic [3:0] es, input logic [3:0] em);
    vec_t v;
    v.rst = r; v.trig = trig; v.pulse = pulse; v.mask = mask;
    v.len = len; v.ld = ld; v.rt = rt; v.es = es; v.em = em;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: actual %b required %b", name, idx, act, exp);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_s      = 1'b1;
    trig_s     = 4'b0000;
    pulse_s    = 4'b0000;
    mask_s     = 4'b0000;
    len_s      = 5'd0;
    len_load_s = 1'b0;
    retrig_s   = 1'b0;

    // Reset: everything low, L = 16.
    for (int i = 0; i < 2; i++) row(1'b1, 4'b0000, 4'b0000, 4'b0000, 5'd0, 1'b0, 1'b0, 4'b0000, 4'b0000);

    // Basic fire on channel 0 with the default length of 16.
    for (int i = 0; i < 30; i++)
      row(1'b0, (i == 10) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000, 5'd0, 1'b0, 1'b0,
          (i >= 10 && i <= 25) ? 4'b0001 : 4'b0000, 4'b0000);

    // L = 4: retriggerable, then non-retriggerable, triggers in rows 0 and 3.
    row(1'b0, 4'b0000, 4'b0000, 4'b0000, 5'd4, 1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++)
      row(1'b0, (i == 0 || i == 3) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000, 5'd0, 1'b0, 1'b1,
          (i <= 6) ? 4'b0001 : 4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++)
      row(1'b0, (i == 0 || i == 3) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000, 5'd0, 1'b0, 1'b0,
          (i <= 3) ? 4'b0001 : 4'b0000, 4'b0000);

    // Held trigger on channel 1: non-retrig gives 4 high / 1 low, retrig stays high.
    for (int i = 0; i < 16; i++)
      row(1'b0, (i <= 11) ? 4'b0010 : 4'b0000, 4'b0000, 4'b0000, 5'd0, 1'b0, 1'b0,
          ((i % 5) != 4 && i <= 13) ? 4'b0010 : 4'b0000, 4'b0000);
    for (int i = 0; i < 15; i++)
      row(1'b0, (i <= 9) ? 4'b0010 : 4'b0000, 4'b0000, 4'b0000, 5'd0, 1'b0, 1'b1,
          (i <= 12) ? 4'b0010 : 4'b0000, 4'b0000);

    // Monitor with L = 8: held pulse gives one monitor firing; masking from row 5
    // blocks the row-9 trigger but not the running monitor pulse.
    row(1'b0, 4'b0000, 4'b0000, 4'b0000, 5'd8, 1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 23; i++)
      row(1'b0, (i == 0 || i == 9) ? 4'b0001 : 4'b0000,
          (i >= 3 && i <= 20) ? 4'b0001 : 4'b0000,
          (i >= 5) ? 4'b0001 : 4'b0000, 5'd0, 1'b0, 1'b0,
          (i <= 7) ? 4'b0001 : 4'b0000,
          (i >= 4 && i <= 11) ? 4'b0001 : 4'b0000);

    // Length 0 is stored as 1.
    row(1'b0, 4'b0000, 4'b0000, 4'b0000, 5'd0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++)
      row(1'b0, (i == 0) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000, 5'd0, 1'b0, 1'b0,
          (i == 0) ? 4'b0100 : 4'b0000, 4'b0000);

    // L = 6 pulse, load 10 mid-pulse: current pulse unchanged, next pulse 10 long.
    row(1'b0, 4'b0000, 4'b0000, 4'b0000, 5'd6, 1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 20; i++)
      row(1'b0, (i == 0 || i == 8) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000,
          (i == 2) ? 5'd10 : 5'd0, (i == 2) ? 1'b1 : 1'b0, 1'b0,
          ((i <= 5) || (i >= 8 && i <= 17)) ? 4'b0100 : 4'b0000, 4'b0000);

    // Masked trigger produces nothing.
    for (int i = 0; i < 4; i++)
      row(1'b0, (i == 0) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0100, 5'd0, 1'b0, 1'b0,
          4'b0000, 4'b0000);

    // Reset 3 rows into an all-channel pulse, overriding trig/pulse/load on that edge;
    // the next trigger right after reset uses L = 16.
    for (int i = 0; i < 22; i++)
      row((i == 3) ? 1'b1 : 1'b0,
          (i == 0 || i == 3) ? 4'b1111 : ((i == 4) ? 4'b1000 : 4'b0000),
          (i >= 1 && i <= 3) ? 4'b1111 : 4'b0000, 4'b0000,
          (i == 3) ? 5'd3 : 5'd0, (i == 3) ? 1'b1 : 1'b0, 1'b0,
          (i <= 2) ? 4'b1111 : ((i >= 4 && i <= 19) ? 4'b1000 : 4'b0000),
          (i == 2) ? 4'b1111 : 4'b0000);

    // Apply rows; expected results go through the scoreboard.
    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      @(negedge clk250_s);
      rst_s      = vecs[i].rst;
      trig_s     = vecs[i].trig;
      pulse_s    = vecs[i].pulse;
      mask_s     = vecs[i].mask;
      len_s      = vecs[i].len;
      len_load_s = vecs[i].ld;
      retrig_s   = vecs[i].rt;
      e.row = i; e.es = vecs[i].es; e.em = vecs[i].em; e.eb = |vecs[i].es;
      sb.push_back(e);
      @(posedge clk250_s);
      #1;
      e = sb.pop_front();
      check("scal", e.row, scal_s, e.es);
      check("mon", e.row, mon_scal_s, e.em);
      check("busy", e.row, {3'b000, busy_s}, {3'b000, e.eb});
    end

    // Hand-written: load 7, single trigger on channel 1, measure the pulse width.
    begin
      int  hi;
      bit  fell;
      hi   = 0;
      fell = 1'b0;
      @(negedge clk250_s);
      rst_s = 1'b0; trig_s = 4'b0000; pulse_s = 4'b0000; mask_s = 4'b0000;
      len_s = 5'd7; len_load_s = 1'b1; retrig_s = 1'b0;
      @(negedge clk250_s);
      len_load_s = 1'b0; trig_s = 4'b0010;
      @(negedge clk250_s);
      trig_s = 4'b0000;
      for (int c = 0; c < 40 && !fell; c++) begin
        if (scal_s[1]) hi++;
        else if (hi > 0) fell = 1'b1;
        if (!fell) @(negedge clk250_s);
      end
      n_checks++;
      if (!fell) begin
        n_fail++;
        $display("FAIL pulse_fall_timeout: actual still-high required low within 40 cycles");
      end
      n_checks++;
      if (hi != 7) begin
        n_fail++;
        $display("FAIL pulse_width_7: actual %0d required 7", hi);
      end
      check("busy_idle", 0, {3'b000, busy_s}, 4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
